uart_tx_scheduler: RTL and testbench

//  Shares one 8N1 UART transmit line (XBee DIN) between NREQ byte sources.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_scheduler_if.sv | 32 +++
 rtl/baud_tick_gen.sv | 33 +++
 rtl/uart_tx_scheduler.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART transmit scheduler.
// Revision : 1.0
// -----------------------------------------------------------------------------
package uart_pkg;
    localparam int DATA_BITS     = 8;
    localparam int DIV_9600_100M = 10416;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        GAP   = 3'd4
    } state_t;
endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : uart_tx_scheduler_if
// Brief    : Requester handshake, status and serial line of the UART scheduler.
// Revision : 1.0
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if
    import uart_pkg::*;
#(
    parameter int NREQ = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]           req_valid;
    logic [DATA_BITS*NREQ-1:0] req_data;
    logic [NREQ-1:0]           req_ready;
    logic [IDW-1:0]            grant_id;
    logic                      busy;
    logic                      frame_done;
    logic                      Tx;

    modport master (
        output req_valid, req_data,
        input  req_ready, grant_id, busy, frame_done, Tx
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, grant_id, busy, frame_done, Tx
    );
endinterface
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : baud_tick_gen
// Brief    : Enable-gated bit-period counter; tick every DIV+1 enabled clocks.
// Revision : 1.0
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int DIV = 10416
) (
    input  wire logic Clk,
    input  wire logic Reset,
    input  wire logic en,
    output logic      tick
);
    localparam int              c_CW   = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [c_CW-1:0] c_TERM = c_CW'(DIV);

    logic [c_CW-1:0] r_cnt;

    // Clearing while disabled aligns the first tick exactly one bit period after a frame starts
    always_ff @(posedge Clk) begin
        if (!Reset || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign tick = en && (r_cnt == c_TERM);
endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : uart_tx_scheduler
// Brief    : Round-robin arbitration of byte sources onto one 8N1 UART line.
// Revision : 1.0
// -----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int DIV      = DIV_9600_100M,
    parameter int NREQ     = 2,
    parameter int GAP_BITS = 1
) (
    input wire logic           Clk,
    input wire logic           Reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int c_IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int c_GW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_tick;
    logic                 w_baud_en;
    logic                 w_found;
    logic                 w_accept;
    logic                 w_tx_next;
    logic                 w_done_next;
    logic [c_IDW-1:0]     w_winner;
    logic [NREQ-1:0]      w_ready;
    logic [DATA_BITS-1:0] w_sel_byte;
    logic [c_IDW-1:0]     r_ptr;
    logic [c_IDW-1:0]     r_grant;
    logic [DATA_BITS-1:0] r_shift;
    logic [2:0]           r_bit_idx;
    logic [c_GW-1:0]      r_gap_cnt;
    logic                 r_tx;
    logic                 r_done;

    assign w_baud_en = (r_state != IDLE);

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (w_baud_en),
        .tick  (w_tick)
    );

    // Search starts just after the last winner so every source gets a turn
    always_comb begin
        logic [c_IDW-1:0] w_idx;
        w_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = c_IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_byte = '0;
        w_ready    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == c_IDW'(i)) begin
                w_sel_byte = bus.req_data[i*DATA_BITS +: DATA_BITS];
                w_ready[i] = (r_state == IDLE) && w_found;
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Tx is registered, so it is driven with the level of the state being entered
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = r_tx;
        w_done_next  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_tx_next = 1'b1;
                if (w_accept) begin
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                    w_tx_next    = r_shift[0];
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_tx_next    = r_shift[1];
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_tx_next = 1'b1;
                    if (GAP_BITS == 0) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = GAP;
                    end
                end
            end
            GAP: begin
                if (w_tick && (int'(r_gap_cnt) == GAP_BITS - 1)) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_ptr     <= c_IDW'(NREQ - 1);
            r_grant   <= '0;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
        end else begin
            r_tx   <= w_tx_next;
            r_done <= w_done_next;
            if (w_accept) begin
                r_ptr   <= w_winner;
                r_grant <= w_winner;
                r_shift <= w_sel_byte;
            end
            if (r_state == DATA && w_tick) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == STOP) begin
                r_gap_cnt <= '0;
            end else if (r_state == GAP && w_tick) begin
                r_gap_cnt <= r_gap_cnt + c_GW'(1);
            end
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.grant_id   = r_grant;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = r_done;
    assign bus.Tx         = r_tx;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : tb_uart_tx_scheduler
// Brief    : Scoreboard bench for the UART scheduler, GAP_BITS=1 and GAP_BITS=0 builds.
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
    localparam int DIV    = 3;
    localparam int NREQ   = 2;
    localparam int BITCLK = DIV + 1;
    localparam int FRAME1 = 11 * BITCLK;
    localparam int FRAME0 = 10 * BITCLK;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    uart_tx_scheduler_if #(.NREQ(NREQ)) bus0 ();
    uart_tx_scheduler_if #(.NREQ(NREQ)) bus1 ();

    uart_tx_scheduler #(.DIV(DIV), .NREQ(NREQ), .GAP_BITS(1)) dut0 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus0.slave)
    );

    uart_tx_scheduler #(.DIV(DIV), .NREQ(NREQ), .GAP_BITS(0)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus1.slave)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   ptr_m = NREQ - 1;
    logic exp_bits[$];

    function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic push_frame(input logic [7:0] d, input int gapb);
        exp_bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) exp_bits.push_back(d[b]);
        exp_bits.push_back(1'b1);
        for (int g = 0; g < gapb; g++) exp_bits.push_back(1'b1);
    endtask

    // Walks cycles 1..FRAME1+1 after an accept on dut0
    task automatic observe_frame(input int exp_id);
        logic exp_b;
        for (int n = 1; n <= FRAME1 + 1; n++) begin
            @(negedge Clk);
            if (n == 1) begin
                n_vec++;
                if (bus0.grant_id !== 1'(exp_id)) begin
                    n_err++;
                    $display("FAIL grant_id: got %0h want %0h", bus0.grant_id, exp_id);
                end
            end
            if (n <= FRAME1) begin
                n_vec++;
                if (bus0.busy !== 1'b1 || bus0.req_ready !== 2'b00) begin
                    n_err++;
                    $display("FAIL busy_frame cyc %0d: busy=%b ready=%b want busy=1 ready=00", n, bus0.busy, bus0.req_ready);
                end
                if ((n - 1) % BITCLK == 2) begin
                    n_vec++;
                    if (exp_bits.size() == 0) begin
                        n_err++;
                        $display("FAIL scoreboard_empty cyc %0d: got Tx=%b want queued bit", n, bus0.Tx);
                    end else begin
                        exp_b = exp_bits.pop_front();
                        if (bus0.Tx !== exp_b) begin
                            n_err++;
                            $display("FAIL tx_bit cyc %0d: got %b want %b", n, bus0.Tx, exp_b);
                        end
                    end
                end
            end
            n_vec++;
            if (bus0.frame_done !== (n == FRAME1 + 1)) begin
                n_err++;
                $display("FAIL frame_done cyc %0d: got %b want %b", n, bus0.frame_done, (n == FRAME1 + 1));
            end
        end
        n_vec++;
        if (bus0.busy !== 1'b0 || bus0.Tx !== 1'b1) begin
            n_err++;
            $display("FAIL end_idle: busy=%b Tx=%b want busy=0 Tx=1", bus0.busy, bus0.Tx);
        end
    endtask

    task automatic test_reset;
        bus0.req_valid = '0; bus0.req_data = '0;
        bus1.req_valid = '0; bus1.req_data = '0;
        Reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            n_vec++;
            if (bus0.Tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.req_ready !== 2'b00 ||
                bus0.frame_done !== 1'b0 || bus0.grant_id !== 1'b0) begin
                n_err++;
                $display("FAIL reset0: Tx=%b busy=%b ready=%b done=%b gid=%b want 1 0 00 0 0",
                         bus0.Tx, bus0.busy, bus0.req_ready, bus0.frame_done, bus0.grant_id);
            end
            n_vec++;
            if (bus1.Tx !== 1'b1 || bus1.busy !== 1'b0 || bus1.req_ready !== 2'b00) begin
                n_err++;
                $display("FAIL reset1: Tx=%b busy=%b ready=%b want 1 0 00", bus1.Tx, bus1.busy, bus1.req_ready);
            end
        end
        @(posedge Clk); #1 Reset = 1'b1;
        ptr_m = NREQ - 1;
        @(negedge Clk);
        n_vec++;
        if (bus0.Tx !== 1'b1 || bus0.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: Tx=%b busy=%b want 1 0", bus0.Tx, bus0.busy);
        end
    endtask

    task automatic test_single;
        int w;
        @(posedge Clk); #1;
        bus0.req_valid = 2'b01;
        bus0.req_data  = {8'h00, 8'hA5};
        @(negedge Clk);
        w = model_winner(bus0.req_valid, ptr_m);
        n_vec++;
        if (bus0.req_ready !== 2'(1 << w)) begin
            n_err++;
            $display("FAIL single_ready: got %b want %b", bus0.req_ready, 2'(1 << w));
        end
        push_frame(8'hA5, 1);
        ptr_m = w;
        @(posedge Clk); #1 bus0.req_valid = 2'b00;
        observe_frame(w);
    endtask

    task automatic test_back_to_back;
        int w;
        @(posedge Clk); #1;
        bus0.req_valid = 2'b11;
        bus0.req_data  = {8'h22, 8'h11};
        @(negedge Clk);
        for (int f = 0; f < 4; f++) begin
            w = model_winner(bus0.req_valid, ptr_m);
            n_vec++;
            if (bus0.req_ready !== 2'(1 << w)) begin
                n_err++;
                $display("FAIL b2b_ready frame %0d: got %b want %b", f, bus0.req_ready, 2'(1 << w));
            end
            push_frame((w == 0) ? 8'h11 : 8'h22, 1);
            ptr_m = w;
            observe_frame(w);
        end
        #1 bus0.req_valid = 2'b00;
    endtask

    task automatic test_reset_midframe;
        int w;
        @(posedge Clk); #1;
        bus0.req_valid = 2'b10;
        bus0.req_data  = {8'h00, 8'hFF};
        @(negedge Clk);
        w = model_winner(bus0.req_valid, ptr_m);
        n_vec++;
        if (bus0.req_ready !== 2'(1 << w)) begin
            n_err++;
            $display("FAIL abort_ready: got %b want %b", bus0.req_ready, 2'(1 << w));
        end
        @(posedge Clk); #1 bus0.req_valid = 2'b00;
        repeat (18) @(negedge Clk);
        n_vec++;
        if (bus0.Tx !== 1'b0 || bus0.busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_pre: Tx=%b busy=%b want 0 1", bus0.Tx, bus0.busy);
        end
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (2) @(negedge Clk);
        n_vec++;
        if (bus0.Tx !== 1'b1 || bus0.busy !== 1'b0 || bus0.grant_id !== 1'b0 || bus0.frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: Tx=%b busy=%b gid=%b done=%b want 1 0 0 0",
                     bus0.Tx, bus0.busy, bus0.grant_id, bus0.frame_done);
        end
        @(posedge Clk); #1 Reset = 1'b1;
        ptr_m = NREQ - 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            n_vec++;
            if (bus0.frame_done !== 1'b0 || bus0.Tx !== 1'b1) begin
                n_err++;
                $display("FAIL abort_quiet cyc %0d: done=%b Tx=%b want 0 1", c, bus0.frame_done, bus0.Tx);
            end
        end
        @(posedge Clk); #1;
        bus0.req_valid = 2'b10;
        bus0.req_data  = {8'h5A, 8'h00};
        @(negedge Clk);
        w = model_winner(bus0.req_valid, ptr_m);
        n_vec++;
        if (bus0.req_ready !== 2'(1 << w)) begin
            n_err++;
            $display("FAIL restart_ready: got %b want %b", bus0.req_ready, 2'(1 << w));
        end
        push_frame(8'h5A, 1);
        ptr_m = w;
        @(posedge Clk); #1 bus0.req_valid = 2'b00;
        observe_frame(w);
    endtask

    task automatic test_valid_while_busy;
        int w;
        @(posedge Clk); #1;
        bus0.req_valid = 2'b01;
        bus0.req_data  = {8'h77, 8'h96};
        @(negedge Clk);
        w = model_winner(bus0.req_valid, ptr_m);
        n_vec++;
        if (bus0.req_ready !== 2'(1 << w)) begin
            n_err++;
            $display("FAIL busy_ready_acc: got %b want %b", bus0.req_ready, 2'(1 << w));
        end
        push_frame(8'h96, 1);
        ptr_m = w;
        fork
            observe_frame(w);
            begin
                @(posedge Clk); #1 bus0.req_valid = 2'b00;
                repeat (9) @(posedge Clk);
                #1 bus0.req_valid = 2'b10;
                repeat (10) @(posedge Clk);
                #1 bus0.req_valid = 2'b00;
            end
        join
        for (int c = 0; c < 5; c++) begin
            n_vec++;
            if (bus0.req_ready !== 2'b00 || bus0.busy !== 1'b0) begin
                n_err++;
                $display("FAIL pulse_ignored cyc %0d: ready=%b busy=%b want 00 0", c, bus0.req_ready, bus0.busy);
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_gap0;
        logic exp_b;
        @(posedge Clk); #1;
        bus1.req_valid = 2'b01;
        bus1.req_data  = {8'h00, 8'hFF};
        @(negedge Clk);
        n_vec++;
        if (bus1.req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL gap0_ready: got %b want 01", bus1.req_ready);
        end
        push_frame(8'hFF, 0);
        @(posedge Clk); #1 bus1.req_valid = 2'b00;
        for (int n = 1; n <= FRAME0 + 1; n++) begin
            @(negedge Clk);
            n_vec++;
            if (bus1.busy !== (n <= FRAME0) || bus1.frame_done !== (n == FRAME0 + 1)) begin
                n_err++;
                $display("FAIL gap0_timing cyc %0d: busy=%b done=%b want %b %b",
                         n, bus1.busy, bus1.frame_done, (n <= FRAME0), (n == FRAME0 + 1));
            end
            if (n <= FRAME0 && (n - 1) % BITCLK == 2) begin
                n_vec++;
                if (exp_bits.size() == 0) begin
                    n_err++;
                    $display("FAIL gap0_scoreboard_empty cyc %0d: got Tx=%b", n, bus1.Tx);
                end else begin
                    exp_b = exp_bits.pop_front();
                    if (bus1.Tx !== exp_b) begin
                        n_err++;
                        $display("FAIL gap0_tx cyc %0d: got %b want %b", n, bus1.Tx, exp_b);
                    end
                end
            end
        end
        n_vec++;
        if (exp_bits.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: got %0d bits want 0", exp_bits.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_midframe();
        test_valid_while_busy();
        test_gap0();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
